// File: rtl/sram_dp_pkg.sv
// Shared constants and helpers for the pipelined dual-port SRAM.
package sram_dp_pkg;

  localparam int DEFAULT_WIDTH   = 8;
  localparam int DEFAULT_DEPTH   = 8;
  localparam int DEFAULT_LATENCY = 5;
  localparam int MAX_LATENCY     = 16;

  // Address width for a given depth; a one-bit address is the minimum.
  function automatic int addr_width(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/sram_dp_delay_line.sv
// LATENCY-deep valid/data shift register. Only the valid chain is cleared;
// each data stage loads only when its incoming valid is set, so the last stage holds.
module sram_dp_delay_line #(
  parameter int WIDTH   = 8,
  parameter int LATENCY = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             vld_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             vld_o,
  output logic [WIDTH-1:0] data_o
);

  for (genvar gi = 0; gi < LATENCY; gi++) begin : g_stage
    logic             vld_reg;
    logic [WIDTH-1:0] data_reg;
    logic             vld_in;
    logic [WIDTH-1:0] data_in;

    if (gi == 0) begin : g_head
      assign vld_in  = vld_i;
      assign data_in = data_i;
    end else begin : g_tail
      assign vld_in  = g_stage[gi-1].vld_reg;
      assign data_in = g_stage[gi-1].data_reg;
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        vld_reg <= 1'b0;
      end else begin
        vld_reg <= vld_in;
      end
    end

    always_ff @(posedge clk_i) begin
      if (vld_in) begin
        data_reg <= data_in;
      end
    end
  end

  assign vld_o  = g_stage[LATENCY-1].vld_reg;
  assign data_o = g_stage[LATENCY-1].data_reg;

endmodule

// File: rtl/sram_dp_pipelined.sv
// Pipelined simple dual-port SRAM: one write and one read per cycle, fixed read latency.
// Define SRAM_DP_WRITE_FORWARD_EN for write-first same-address behaviour (read-first otherwise).
module sram_dp_pipelined
  import sram_dp_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int LATENCY = DEFAULT_LATENCY
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         wen_i,
  input  logic                         ren_i,
  input  logic [addr_width(DEPTH)-1:0] waddr_i,
  input  logic [addr_width(DEPTH)-1:0] raddr_i,
  input  logic [WIDTH-1:0]             data_i,
  output logic [WIDTH-1:0]             data_o,
  output logic                         vld_o
);

  localparam int AW = addr_width(DEPTH);
  localparam logic [AW:0] DEPTH_LIMIT = DEPTH[AW:0];

  if (LATENCY < 1 || LATENCY > MAX_LATENCY) begin : g_bad_latency
    $error("sram_dp_pipelined: LATENCY out of range");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_in_range;
  logic             rd_in_range;
  logic [WIDTH-1:0] rd_word;
  logic             dl_vld;
  logic [WIDTH-1:0] dl_data;
  logic             have_data_reg;

  assign wr_in_range = ({1'b0, waddr_i} < DEPTH_LIMIT);
  assign rd_in_range = ({1'b0, raddr_i} < DEPTH_LIMIT);

  always_ff @(posedge clk_i) begin
    if (wen_i && wr_in_range) begin
      mem[waddr_i] <= data_i;
    end
  end

  // Out-of-range reads still travel the pipe, carrying zero.
  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
`ifdef SRAM_DP_WRITE_FORWARD_EN
      if (wen_i && (waddr_i == raddr_i)) begin
        rd_word = data_i;
      end else begin
        rd_word = mem[raddr_i];
      end
`else
      rd_word = mem[raddr_i];
`endif
    end
  end

  // Stage 0 of the delay line is the registered array read.
  sram_dp_delay_line #(
    .WIDTH  (WIDTH),
    .LATENCY(LATENCY)
  ) u_delay_line (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .vld_i (ren_i),
    .data_i(rd_word),
    .vld_o (dl_vld),
    .data_o(dl_data)
  );

  // The data chain has no reset, so data_o reads zero until a post-reset result lands.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      have_data_reg <= 1'b0;
    end else if (dl_vld) begin
      have_data_reg <= 1'b1;
    end
  end

  assign vld_o  = dl_vld;
  assign data_o = (have_data_reg || dl_vld) ? dl_data : '0;

endmodule

// File: tb/tb_sram_dp_pipelined.sv
// Scoreboard bench: unit 0 uses default parameters, unit 1 uses DEPTH=6, LATENCY=1.
module tb_sram_dp_pipelined;

  localparam int W  = 8;
  localparam int AW = 3;

  typedef struct {
    logic [W-1:0] data;
    int           due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst   [2];
  logic          wen   [2];
  logic          ren   [2];
  logic [AW-1:0] waddr [2];
  logic [AW-1:0] raddr [2];
  logic [W-1:0]  wdata [2];
  logic [W-1:0]  rdata [2];
  logic          vld   [2];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_unit
    localparam int UD = (gi == 0) ? 8 : 6;
    localparam int UL = (gi == 0) ? 5 : 1;

    exp_t         q[$];
    logic [W-1:0] mdl [8] = '{default: '0};
    int           edge_n   = 0;
    int           rst_edge = -1;
    logic [W-1:0] exp_last = '0;

    sram_dp_pipelined #(
      .WIDTH  (W),
      .DEPTH  (UD),
      .LATENCY(UL)
    ) u_dut (
      .clk_i  (clk),
      .rst_i  (rst[gi]),
      .wen_i  (wen[gi]),
      .ren_i  (ren[gi]),
      .waddr_i(waddr[gi]),
      .raddr_i(raddr[gi]),
      .data_i (wdata[gi]),
      .data_o (rdata[gi]),
      .vld_o  (vld[gi])
    );

    // Model: expected results are pushed at the issue edge with their due edge.
    always @(posedge clk) begin
      exp_t e;
      edge_n++;
      if (rst[gi]) begin
        q.delete();
        rst_edge = edge_n;
      end else if (ren[gi]) begin
        if (int'(raddr[gi]) >= UD) e.data = '0;
`ifdef SRAM_DP_WRITE_FORWARD_EN
        else if (wen[gi] && (waddr[gi] == raddr[gi])) e.data = wdata[gi];
`endif
        else e.data = mdl[raddr[gi]];
        e.due = edge_n + UL - 1;
        q.push_back(e);
      end
      if (wen[gi] && (int'(waddr[gi]) < UD)) mdl[waddr[gi]] = wdata[gi];
    end

    // Monitor: every cycle, vld_o must match the due entry and data_o the last result.
    always @(negedge clk) begin
      exp_t e;
      logic exp_vld;
      if (edge_n > 0) begin
        if (rst_edge == edge_n) exp_last = '0;
        exp_vld = (q.size() != 0) && (q[0].due == edge_n);
        if (exp_vld) begin
          e = q.pop_front();
          exp_last = e.data;
        end
        check($sformatf("u%0d vld e%0d", gi, edge_n), 32'(vld[gi]), 32'(exp_vld));
        check($sformatf("u%0d data e%0d", gi, edge_n), 32'(rdata[gi]), 32'(exp_last));
      end
    end
  end

  task automatic step(input int u, input logic w, input int wa, input int wd,
                      input logic r, input int ra);
    wen[u]   = w;
    waddr[u] = AW'(wa);
    wdata[u] = W'(wd);
    ren[u]   = r;
    raddr[u] = AW'(ra);
    @(negedge clk);
    wen[u] = 1'b0;
    ren[u] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      rst[u] = 1'b1; wen[u] = 1'b0; ren[u] = 1'b0;
      waddr[u] = '0; raddr[u] = '0; wdata[u] = '0;
    end
    idle(2);
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    // Unit 0: fill, then back-to-back reads 0..7 -> 0x10..0x17
    for (int a = 0; a < 8; a++) step(0, 1'b1, a, a + 'h10, 1'b0, 0);
    for (int a = 0; a < 8; a++) step(0, 1'b0, 0, 0, 1'b1, a);
    idle(6);
    // Write then read one cycle later
    step(0, 1'b1, 3, 'hA5, 1'b0, 0);
    step(0, 1'b0, 0, 0, 1'b1, 3);
    idle(7);
    // Same-edge write/read to one address
    step(0, 1'b1, 2, 'h77, 1'b0, 0);
    step(0, 1'b1, 2, 'h3C, 1'b1, 2);
    step(0, 1'b0, 0, 0, 1'b1, 2);
    idle(7);
    // Same-edge write/read to different addresses
    step(0, 1'b1, 5, 'h55, 1'b1, 0);
    step(0, 1'b0, 0, 0, 1'b1, 5);
    idle(6);
    // Three reads in flight killed by reset; first read afterwards completes
    step(0, 1'b0, 0, 0, 1'b1, 0);
    step(0, 1'b0, 0, 0, 1'b1, 1);
    step(0, 1'b0, 0, 0, 1'b1, 3);
    idle(1);
    rst[0] = 1'b1;
    idle(1);
    rst[0] = 1'b0;
    step(0, 1'b0, 0, 0, 1'b1, 3);
    idle(7);
    for (int i = 0; i < 40; i++)
      step(0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
    idle(7);

    // Unit 1 (DEPTH=6, LATENCY=1)
    for (int a = 0; a < 6; a++) step(1, 1'b1, a, a + 'h20, 1'b0, 0);
    step(1, 1'b1, 1, 'h42, 1'b0, 0);
    step(1, 1'b0, 0, 0, 1'b1, 1);
    idle(2);
    step(1, 1'b1, 7, 'hFF, 1'b0, 0);
    step(1, 1'b1, 6, 'hEE, 1'b1, 7);
    step(1, 1'b0, 0, 0, 1'b1, 6);
    for (int a = 0; a < 6; a++) step(1, 1'b0, 0, 0, 1'b1, a);
    idle(2);
    for (int i = 0; i < 30; i++)
      step(1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
    idle(3);

    check("drain_u0", 32'(g_unit[0].q.size()), 32'd0);
    check("drain_u1", 32'(g_unit[1].q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
